// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS controller with memory ready handshakes,
// trapping addi, retired-instruction counter and illegal flag.
module mc_ctrl_hs #(
   parameter int MEM_HS = 1,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             overflow,
   input  logic             im_rdy,
   input  logic             dm_rdy,
   output logic             im_req,
   output logic             dm_req,
   output logic             pcwr,
   output logic             irwr,
   output logic             gprwr,
   output logic             dmwr,
   output logic             islb,
   output logic             issb,
   output logic [2:0]       aluop,
   output logic [1:0]       extop,
   output logic [1:0]       gprsel,
   output logic [1:0]       wdsel,
   output logic [1:0]       npcop,
   output logic             bsel,
   output logic             ill_instr,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;
   localparam logic [2:0] ALU_LUI = 3'b100;

   state_t           r_state;
   state_t           w_next;
   logic             r_ovf;
   logic             w_ovf_ld;
   logic             w_retire;
   logic [CNT_W-1:0] r_instret;

   logic w_im_rdy;
   logic w_dm_rdy;

   logic w_rtype;
   logic w_addu;
   logic w_subu;
   logic w_slt;
   logic w_jr;
   logic w_ori;
   logic w_lui;
   logic w_addi;
   logic w_lw;
   logic w_sw;
   logic w_lb;
   logic w_sb;
   logic w_beq;
   logic w_j;
   logic w_jal;
   logic w_ralu;
   logic w_load;
   logic w_store;
   logic w_legal;

   // With handshakes disabled the memories are treated as always ready
   assign w_im_rdy = (MEM_HS != 0) ? im_rdy : 1'b1;
   assign w_dm_rdy = (MEM_HS != 0) ? dm_rdy : 1'b1;

   // Instruction decode from opcode/funct
   always_comb begin
      w_rtype = 1'b0;
      w_addu  = 1'b0;
      w_subu  = 1'b0;
      w_slt   = 1'b0;
      w_jr    = 1'b0;
      w_ori   = 1'b0;
      w_lui   = 1'b0;
      w_addi  = 1'b0;
      w_lw    = 1'b0;
      w_sw    = 1'b0;
      w_lb    = 1'b0;
      w_sb    = 1'b0;
      w_beq   = 1'b0;
      w_j     = 1'b0;
      w_jal   = 1'b0;
      case (opcode)
         6'b000000: begin
            w_rtype = 1'b1;
            case (funct)
               6'b100001: w_addu = 1'b1;
               6'b100011: w_subu = 1'b1;
               6'b101010: w_slt  = 1'b1;
               6'b001000: w_jr   = 1'b1;
               default:   w_rtype = 1'b0;
            endcase
         end
         6'b001101: w_ori  = 1'b1;
         6'b001111: w_lui  = 1'b1;
         6'b001000: w_addi = 1'b1;
         6'b100011: w_lw   = 1'b1;
         6'b101011: w_sw   = 1'b1;
         6'b100000: w_lb   = 1'b1;
         6'b101000: w_sb   = 1'b1;
         6'b000100: w_beq  = 1'b1;
         6'b000010: w_j    = 1'b1;
         6'b000011: w_jal  = 1'b1;
         default:   ;
      endcase
   end

   assign w_ralu  = w_addu | w_subu | w_slt;
   assign w_load  = w_lw | w_lb;
   assign w_store = w_sw | w_sb;
   assign w_legal = w_ralu | w_jr | w_ori | w_lui | w_addi
                  | w_load | w_store | w_beq | w_j | w_jal;

   // Next-state and strobe/select generation; reset forces all quiet
   always_comb begin
      w_next    = r_state;
      w_ovf_ld  = 1'b0;
      w_retire  = 1'b0;
      im_req    = 1'b0;
      dm_req    = 1'b0;
      pcwr      = 1'b0;
      irwr      = 1'b0;
      gprwr     = 1'b0;
      dmwr      = 1'b0;
      islb      = 1'b0;
      issb      = 1'b0;
      aluop     = ALU_ADD;
      extop     = 2'b00;
      gprsel    = 2'b00;
      wdsel     = 2'b00;
      npcop     = 2'b00;
      bsel      = 1'b0;
      ill_instr = 1'b0;
      case (r_state)
         S_IF: begin
            im_req = 1'b1;
            if (w_im_rdy) begin
               pcwr   = 1'b1;
               irwr   = 1'b1;
               w_next = S_ID;
            end
         end
         S_ID: begin
            if (w_j) begin
               pcwr     = 1'b1;
               npcop    = 2'b10;
               w_retire = 1'b1;
               w_next   = S_IF;
            end else if (w_jal) begin
               pcwr     = 1'b1;
               npcop    = 2'b10;
               gprwr    = 1'b1;
               gprsel   = 2'b10;
               wdsel    = 2'b10;
               w_retire = 1'b1;
               w_next   = S_IF;
            end else if (w_jr) begin
               pcwr     = 1'b1;
               npcop    = 2'b11;
               w_retire = 1'b1;
               w_next   = S_IF;
            end else if (!w_legal) begin
               ill_instr = 1'b1;
               w_next    = S_IF;
            end else begin
               w_next = S_EXE;
            end
         end
         S_EXE: begin
            if (w_ralu) begin
               bsel   = 1'b0;
               aluop  = w_subu ? ALU_SUB :
                        w_slt  ? ALU_SLT : ALU_ADD;
               w_next = S_WB;
            end else if (w_ori) begin
               bsel   = 1'b1;
               aluop  = ALU_OR;
               w_next = S_WB;
            end else if (w_lui) begin
               bsel   = 1'b1;
               extop  = 2'b10;
               aluop  = ALU_LUI;
               w_next = S_WB;
            end else if (w_addi) begin
               bsel     = 1'b1;
               extop    = 2'b01;
               w_ovf_ld = 1'b1;
               w_next   = S_WB;
            end else if (w_beq) begin
               aluop    = ALU_SUB;
               npcop    = 2'b01;
               pcwr     = zero;
               w_retire = 1'b1;
               w_next   = S_IF;
            end else if (w_load | w_store) begin
               bsel   = 1'b1;
               extop  = 2'b01;
               w_next = S_MEM;
            end else begin
               w_next = S_IF;
            end
         end
         S_MEM: begin
            dm_req = 1'b1;
            islb   = w_lb;
            issb   = w_sb;
            if (w_store) begin
               dmwr = w_dm_rdy;
               if (w_dm_rdy) begin
                  w_retire = 1'b1;
                  w_next   = S_IF;
               end
            end else if (w_dm_rdy) begin
               w_next = S_WB;
            end
         end
         S_WB: begin
            gprsel   = w_rtype ? 2'b01 : 2'b00;
            wdsel    = w_load ? 2'b01 : 2'b00;
            islb     = w_lb;
            gprwr    = !(w_addi && r_ovf);
            w_retire = 1'b1;
            w_next   = S_IF;
         end
         default: w_next = S_IF;
      endcase
      if (rst) begin
         w_ovf_ld  = 1'b0;
         w_retire  = 1'b0;
         im_req    = 1'b0;
         dm_req    = 1'b0;
         pcwr      = 1'b0;
         irwr      = 1'b0;
         gprwr     = 1'b0;
         dmwr      = 1'b0;
         islb      = 1'b0;
         issb      = 1'b0;
         aluop     = ALU_ADD;
         extop     = 2'b00;
         gprsel    = 2'b00;
         wdsel     = 2'b00;
         npcop     = 2'b00;
         bsel      = 1'b0;
         ill_instr = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IF;
      else     r_state <= w_next;
   end

   // Latched addi overflow, consumed in WB to suppress the write
   always_ff @(posedge clk) begin
      if (rst)           r_ovf <= 1'b0;
      else if (w_ovf_ld) r_ovf <= overflow;
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk) begin
      if (rst)           r_instret <= '0;
      else if (w_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign instret = r_instret;
   assign state   = r_state;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs with hand-computed expectations.
module tb_mc_ctrl_hs;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        overflow;
   logic        im_rdy;
   logic        dm_rdy;
   logic        im_req;
   logic        dm_req;
   logic        pcwr;
   logic        irwr;
   logic        gprwr;
   logic        dmwr;
   logic        islb;
   logic        issb;
   logic [2:0]  aluop;
   logic [1:0]  extop;
   logic [1:0]  gprsel;
   logic [1:0]  wdsel;
   logic [1:0]  npcop;
   logic        bsel;
   logic        ill_instr;
   logic [31:0] instret;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int c0;

   mc_ctrl_hs #(.MEM_HS(1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .zero(zero), .overflow(overflow),
      .im_rdy(im_rdy), .dm_rdy(dm_rdy),
      .im_req(im_req), .dm_req(dm_req), .pcwr(pcwr), .irwr(irwr),
      .gprwr(gprwr), .dmwr(dmwr), .islb(islb), .issb(issb),
      .aluop(aluop), .extop(extop), .gprsel(gprsel), .wdsel(wdsel),
      .npcop(npcop), .bsel(bsel), .ill_instr(ill_instr),
      .instret(instret), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Present an instruction and let IF complete in one cycle
   task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
      im_rdy = 1'b1;
      #1;
      step();
   endtask

   function automatic logic [6:0] strobes();
      return {im_req, dm_req, pcwr, irwr, gprwr, dmwr, ill_instr};
   endfunction

   function automatic logic [13:0] selects();
      return {islb, issb, aluop, extop, gprsel, wdsel, npcop, bsel};
   endfunction

   initial begin
      // reset with arbitrary inputs
      rst = 1'b1; opcode = 6'h23; funct = 6'h21;
      zero = 1'b1; overflow = 1'b1; im_rdy = 1'b1; dm_rdy = 1'b1;
      #1;
      chk("rst_strobes", 32'(strobes()), 0);
      chk("rst_selects", 32'(selects()), 0);
      step();
      step();
      chk("rst_state", 32'(state), 0);
      chk("rst_instret", instret, 0);
      chk("rst_strobes2", 32'(strobes()), 0);
      rst = 1'b0; zero = 1'b0; overflow = 1'b0; dm_rdy = 1'b0;
      #1;
      chk("post_rst_imreq", 32'(im_req), 1);

      // addu with 3 cycles of instruction memory wait
      opcode = 6'h00; funct = 6'h21; im_rdy = 1'b0;
      #1;
      c0 = cyc;
      for (int i = 0; i < 3; i++) begin
         chk("if_wait_pcwr", 32'(pcwr), 0);
         chk("if_wait_irwr", 32'(irwr), 0);
         chk("if_wait_imreq", 32'(im_req), 1);
         step();
         chk("if_wait_state", 32'(state), 0);
      end
      im_rdy = 1'b1;
      #1;
      chk("if_pcwr", 32'(pcwr), 1);
      chk("if_irwr", 32'(irwr), 1);
      step();
      chk("addu_id_state", 32'(state), 1);
      chk("addu_id_irwr", 32'(irwr), 0);
      chk("addu_id_pcwr", 32'(pcwr), 0);
      step();
      chk("addu_exe_state", 32'(state), 2);
      chk("addu_exe_alu", 32'(aluop), 0);
      chk("addu_exe_bsel", 32'(bsel), 0);
      step();
      chk("addu_wb_state", 32'(state), 4);
      chk("addu_wb_gprwr", 32'(gprwr), 1);
      chk("addu_wb_gprsel", 32'(gprsel), 1);
      chk("addu_wb_wdsel", 32'(wdsel), 0);
      step();
      chk("addu_cycles", 32'(cyc - c0), 7);
      chk("addu_instret", instret, 1);

      // lw with data memory ready after 2 wait cycles
      c0 = cyc;
      dm_rdy = 1'b0;
      fetch(6'h23, 6'h00);
      step();
      chk("lw_exe_alu", 32'(aluop), 0);
      chk("lw_exe_bsel", 32'(bsel), 1);
      chk("lw_exe_extop", 32'(extop), 1);
      step();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) dm_rdy = 1'b1;
         #1;
         chk("lw_mem_state", 32'(state), 3);
         chk("lw_mem_dmreq", 32'(dm_req), 1);
         chk("lw_mem_dmwr", 32'(dmwr), 0);
         step();
      end
      dm_rdy = 1'b0;
      #1;
      chk("lw_wb_state", 32'(state), 4);
      chk("lw_wb_wdsel", 32'(wdsel), 1);
      chk("lw_wb_gprwr", 32'(gprwr), 1);
      chk("lw_wb_dmreq", 32'(dm_req), 0);
      step();
      chk("lw_cycles", 32'(cyc - c0), 7);
      chk("lw_instret", instret, 2);

      // sb with immediate data memory ready
      c0 = cyc;
      dm_rdy = 1'b1;
      fetch(6'h28, 6'h00);
      step();
      step();
      chk("sb_mem_dmwr", 32'(dmwr), 1);
      chk("sb_mem_issb", 32'(issb), 1);
      chk("sb_mem_islb", 32'(islb), 0);
      step();
      chk("sb_cycles", 32'(cyc - c0), 4);
      chk("sb_dmwr_after", 32'(dmwr), 0);
      chk("sb_state", 32'(state), 0);
      chk("sb_instret", instret, 3);

      // beq taken then not taken
      zero = 1'b1;
      fetch(6'h04, 6'h00);
      step();
      chk("beq_t_pcwr", 32'(pcwr), 1);
      chk("beq_t_npcop", 32'(npcop), 1);
      chk("beq_t_alu", 32'(aluop), 1);
      step();
      chk("beq_t_state", 32'(state), 0);
      chk("beq_t_instret", instret, 4);
      zero = 1'b0;
      fetch(6'h04, 6'h00);
      step();
      chk("beq_nt_pcwr", 32'(pcwr), 0);
      step();
      chk("beq_nt_state", 32'(state), 0);
      chk("beq_nt_instret", instret, 5);

      // addi with overflow traps the write, then without
      fetch(6'h08, 6'h00);
      step();
      overflow = 1'b1;
      #1;
      chk("addi_exe_extop", 32'(extop), 1);
      step();
      overflow = 1'b0;
      #1;
      chk("addi_ovf_gprwr", 32'(gprwr), 0);
      step();
      chk("addi_ovf_instret", instret, 6);
      fetch(6'h08, 6'h00);
      step();
      step();
      chk("addi_ok_gprwr", 32'(gprwr), 1);
      step();
      chk("addi_ok_instret", instret, 7);

      // jal completes in ID
      fetch(6'h03, 6'h00);
      chk("jal_gprwr", 32'(gprwr), 1);
      chk("jal_gprsel", 32'(gprsel), 2);
      chk("jal_wdsel", 32'(wdsel), 2);
      chk("jal_pcwr", 32'(pcwr), 1);
      chk("jal_npcop", 32'(npcop), 2);
      step();
      chk("jal_state", 32'(state), 0);
      chk("jal_instret", instret, 8);

      // illegal opcode pulses the flag once, not counted
      fetch(6'h3f, 6'h00);
      chk("ill_pulse", 32'(ill_instr), 1);
      step();
      chk("ill_state", 32'(state), 0);
      chk("ill_clear", 32'(ill_instr), 0);
      chk("ill_instret", instret, 8);

      // reset during MEM abandons the load
      dm_rdy = 1'b0;
      fetch(6'h23, 6'h00);
      step();
      step();
      chk("rstmem_dmreq_pre", 32'(dm_req), 1);
      rst = 1'b1;
      #1;
      chk("rstmem_dmreq", 32'(dm_req), 0);
      step();
      rst = 1'b0;
      #1;
      chk("rstmem_state", 32'(state), 0);
      chk("rstmem_instret", instret, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
